color_select_ctrl: RTL

Hardware replacement for the software pushbutton colour-selector loop. Debounces the three pushbuttons, keeps an RGB565 colour and a channel-select pointer (R/G/B), applies increment/decrement to the selected channel, and sequences a full-frame OLED fill whenever the colour changes. It sits beside the processor in `Wrapper`: its outputs drive the OLED pixel port, and the colour and select values are readable on the seven-segment and LED paths.

---
 rtl/color_select_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/color_select_ctrl.sv
// -----------------------------------------------------------------------------
// color_select_ctrl
//
// Pushbutton-driven RGB565 colour selector with OLED full-frame fill sequencer.
// The three raw pushbuttons are synchronized and debounced. A debounced press
// of exactly one button, starting from all-released, performs one action:
//   PB[2] increments the selected channel, PB[1] steps the channel select
//   R -> G -> B -> R, and PB[0] decrements the selected channel.
// Whenever the colour value actually changes, a full-frame sweep of pixel
// writes is issued to the OLED at one pixel per cycle.
//
// Optional feature (compile-time macro COLOR_WRAP_EN):
//   defined   - increment at the field maximum wraps to 0, and decrement at 0
//               wraps to the maximum
//   undefined - channels saturate at 0 and at the field maximum
//
// Parameters:
//   DEBOUNCE_CYCLES - stable synchronized cycles needed to accept a PB vector
//   OLED_COLS       - pixel columns per fill
//   OLED_ROWS       - pixel rows per fill
//
// Ports:
//   CLK        in   sole clock, rising edge
//   RESETn     in   asynchronous active-low reset
//   PB[2:0]    in   raw pushbuttons {inc, select, dec}
//   COLOR      out  current colour {R[4:0], G[5:0], B[4:0]}
//   SEL        out  selected channel (0 = R, 1 = G, 2 = B)
//   OLED_Write out  pixel write strobe
//   OLED_Col   out  pixel column
//   OLED_Row   out  pixel row
//   OLED_Data  out  pixel colour {R8, G8, B8}
//   BUSY       out  high while a fill is in progress
// -----------------------------------------------------------------------------
module color_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OLED_COLS       = 96,
  parameter int OLED_ROWS       = 64
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [2:0]  PB,
  output logic [15:0] COLOR,
  output logic [1:0]  SEL,
  output logic        OLED_Write,
  output logic [6:0]  OLED_Col,
  output logic [5:0]  OLED_Row,
  output logic [23:0] OLED_Data,
  output logic        BUSY
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [6:0]      COL_LAST = 7'(OLED_COLS - 1);
  localparam logic [5:0]      ROW_LAST = 6'(OLED_ROWS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizer and debouncer
  // ---------------------------------------------------------------------------
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    cand_q;      // vector currently being timed for stability
  logic [CW-1:0] cnt_q;       // consecutive cycles cand_q has been observed
  logic [2:0]    pb_db_q;
  logic [2:0]    pb_prev_q;   // pb_db one cycle ago, for edge detection

  // NOTE: sequential state is written only with non-blocking (<=) assignments
  // so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1_q   <= 3'b000;
      sync2_q   <= 3'b000;
      cand_q    <= 3'b000;
      cnt_q     <= '0;
      pb_db_q   <= 3'b000;
      pb_prev_q <= 3'b000;
    end else begin
      sync1_q   <= PB;
      sync2_q   <= sync1_q;
      pb_prev_q <= pb_db_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= CW'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CW'(1);
      end
      // cand_q has been seen for DEBOUNCE_CYCLES consecutive cycles.
      if (cnt_q == CNT_MAX) begin
        pb_db_q <= cand_q;
      end
    end
  end

  // An action fires only on a released -> single-button transition.
  logic fire;
  assign fire = (pb_prev_q == 3'b000) &&
                ((pb_db_q == 3'b100) || (pb_db_q == 3'b010) || (pb_db_q == 3'b001));

  // ---------------------------------------------------------------------------
  // Colour / select update
  // ---------------------------------------------------------------------------
  logic [15:0] color_q, color_d;
  logic [1:0]  sel_q, sel_d;
  logic        color_change;

  // One step of a channel value in [0, max], saturating or wrapping at the ends.
  function automatic logic [5:0] chan_step(input logic [5:0] v,
                                           input logic [5:0] max,
                                           input logic       up);
    logic [5:0] r;
    r = v;
    if (up) begin
      if (v != max)  r = v + 6'd1;
`ifdef COLOR_WRAP_EN
      else           r = 6'd0;
`endif
    end else begin
      if (v != 6'd0) r = v - 6'd1;
`ifdef COLOR_WRAP_EN
      else           r = max;
`endif
    end
    return r;
  endfunction

  // NOTE: every combinational output gets a default first, so no path through
  // the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    logic [5:0] r6, g6, b6;
    logic       up;
    color_d = color_q;
    sel_d   = sel_q;
    r6      = {1'b0, color_q[15:11]};
    g6      = color_q[10:5];
    b6      = {1'b0, color_q[4:0]};
    up      = pb_db_q[2];
    if (fire) begin
      if (pb_db_q == 3'b010) begin
        sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
      end else begin
        case (sel_q)
          2'd0:    r6 = chan_step(r6, 6'd31, up);
          2'd1:    g6 = chan_step(g6, 6'd63, up);
          default: b6 = chan_step(b6, 6'd31, up);
        endcase
        color_d = {r6[4:0], g6, b6[4:0]};
      end
    end
  end

  assign color_change = (color_d != color_q);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      color_q <= 16'h0000;
      sel_q   <= 2'd0;
    end else begin
      color_q <= color_d;
      sel_q   <= sel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fill FSM
  // From IDLE, a colour change is held in pending_q so the first write lands
  // the cycle after COLOR updates. During FILL, a colour change restarts the
  // sweep on the same edge that updates COLOR, so no pixel after the change
  // carries the old colour; it also takes priority over finishing.
  // ---------------------------------------------------------------------------
  state_e     state_q;
  logic       pending_q;
  logic [6:0] col_q;
  logic [5:0] row_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      col_q     <= 7'd0;
      row_q     <= 6'd0;
    end else begin
      pending_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            state_q <= ST_FILL;
            col_q   <= 7'd0;
            row_q   <= 6'd0;
          end else if (color_change) begin
            pending_q <= 1'b1;
          end
        end
        default: begin
          if (color_change) begin
            col_q <= 7'd0;
            row_q <= 6'd0;
          end else if (col_q == COL_LAST) begin
            col_q <= 7'd0;
            if (row_q == ROW_LAST) begin
              row_q   <= 6'd0;
              state_q <= ST_IDLE;
            end else begin
              row_q <= row_q + 6'd1;
            end
          end else begin
            col_q <= col_q + 7'd1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all taken directly from registers)
  // ---------------------------------------------------------------------------
  assign COLOR      = color_q;
  assign SEL        = sel_q;
  assign OLED_Write = (state_q == ST_FILL);
  assign BUSY       = (state_q == ST_FILL);
  assign OLED_Col   = col_q;
  assign OLED_Row   = row_q;
  // Replicate the top bits so full-scale 5/6-bit values map to 8'hFF.
  assign OLED_Data  = {color_q[15:11], color_q[15:13],
                       color_q[10:5],  color_q[10:9],
                       color_q[4:0],   color_q[4:2]};

endmodule
